// File: rtl/mem_to_reg_pkg.sv
// rtl/mem_to_reg_pkg.sv - shared constants and extension helpers for the write-back selector
package mem_to_reg_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LW  = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;

  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] h);
    return {{16{h[15]}}, h};
  endfunction

endpackage

// File: rtl/mem_to_reg_mux_load_align_extend.sv
// rtl/mem_to_reg_mux_load_align_extend.sv - combinational big-endian lane pick and extension
module load_align_extend
  import mem_to_reg_pkg::*;
(
  input  logic [31:0] mem_data,
  input  logic [2:0]  load_type,
  input  logic [1:0]  byte_offset,
  output logic [31:0] load_value
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Big-endian: offset 0 is the most significant byte.
  always_comb begin
    byte_lane = mem_data[31:24];
    case (byte_offset)
      2'd0: byte_lane = mem_data[31:24];
      2'd1: byte_lane = mem_data[23:16];
      2'd2: byte_lane = mem_data[15:8];
      2'd3: byte_lane = mem_data[7:0];
      default: byte_lane = mem_data[31:24];
    endcase
    half_lane = byte_offset[1] ? mem_data[15:0] : mem_data[31:16];
  end

  always_comb begin
    load_value = mem_data;
    case (load_type)
      LT_LB:   load_value = sext8(byte_lane);
      LT_LBU:  load_value = {24'h0, byte_lane};
      LT_LH:   load_value = sext16(half_lane);
      LT_LHU:  load_value = {16'h0, half_lane};
      LT_LW:   load_value = mem_data;
      default: load_value = mem_data;
    endcase
  end

endmodule

// File: rtl/mem_to_reg_mux.sv
// rtl/mem_to_reg_mux.sv - registered write-back source selector (ALU vs load data)
// Optional MEMTOREG_LINK_EN adds pc_plus_8/link_sel for jal link writes.
module mem_to_reg_mux
  import mem_to_reg_pkg::*;
#(
  parameter int DATA_W = mem_to_reg_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              mem_to_reg,
  input  logic [2:0]        load_type,
  input  logic [1:0]        byte_offset,
  input  logic              wb_en,
`ifdef MEMTOREG_LINK_EN
  input  logic [DATA_W-1:0] pc_plus_8,
  input  logic              link_sel,
`endif
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_valid
);

  logic [DATA_W-1:0] load_value;
  logic [DATA_W-1:0] sel_value;
  logic [DATA_W-1:0] wb_data_d, wb_data_q;
  logic              wb_valid_d, wb_valid_q;

  load_align_extend u_load_align_extend (
    .mem_data    (mem_data),
    .load_type   (load_type),
    .byte_offset (byte_offset),
    .load_value  (load_value)
  );

  always_comb begin
    sel_value = mem_to_reg ? load_value : alu_result;
`ifdef MEMTOREG_LINK_EN
    if (link_sel) sel_value = pc_plus_8;
`endif
  end

  always_comb begin
    wb_valid_d = wb_en;
    wb_data_d  = wb_en ? sel_value : wb_data_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wb_data_q  <= '0;
      wb_valid_q <= 1'b0;
    end else begin
      wb_data_q  <= wb_data_d;
      wb_valid_q <= wb_valid_d;
    end
  end

  assign wb_data  = wb_data_q;
  assign wb_valid = wb_valid_q;

endmodule

// File: tb/tb_mem_to_reg_mux.sv
// tb/tb_mem_to_reg_mux.sv - self-checking bench for mem_to_reg_mux
module tb_mem_to_reg_mux;

  logic        clock;
  logic        reset;
  logic [31:0] mem_data;
  logic [31:0] alu_result;
  logic        mem_to_reg;
  logic [2:0]  load_type;
  logic [1:0]  byte_offset;
  logic        wb_en;
`ifdef MEMTOREG_LINK_EN
  logic [31:0] pc_plus_8;
  logic        link_sel;
`endif
  logic [31:0] wb_data;
  logic        wb_valid;

  int total = 0;
  int bad   = 0;

  mem_to_reg_mux dut (
    .clock       (clock),
    .reset       (reset),
    .mem_data    (mem_data),
    .alu_result  (alu_result),
    .mem_to_reg  (mem_to_reg),
    .load_type   (load_type),
    .byte_offset (byte_offset),
    .wb_en       (wb_en),
`ifdef MEMTOREG_LINK_EN
    .pc_plus_8   (pc_plus_8),
    .link_sel    (link_sel),
`endif
    .wb_data     (wb_data),
    .wb_valid    (wb_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: arithmetic on big-endian byte numbering, independent of RTL structure.
  function automatic logic [31:0] model(input logic [31:0] mem, input logic [31:0] alu,
                                        input logic m2r, input logic [2:0] lt,
                                        input logic [1:0] off, input logic lnk,
                                        input logic [31:0] pc);
    logic [31:0] v;
    int          sh;
    if (lnk) return pc;
    if (!m2r) return alu;
    case (lt)
      3'b000, 3'b100: begin
        sh = 8 * (3 - int'(off));
        v  = (mem >> sh) & 32'h0000_00FF;
        if (lt == 3'b000 && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end
      3'b001, 3'b101: begin
        sh = 16 * (1 - int'(off) / 2);
        v  = (mem >> sh) & 32'h0000_FFFF;
        if (lt == 3'b001 && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end
      default: v = mem;
    endcase
    return v;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mem_data = $urandom; alu_result = $urandom; mem_to_reg = 1'($urandom);
      load_type = 3'($urandom); byte_offset = 2'($urandom); wb_en = 1'($urandom);
      step();
      total++;
      if (wb_data !== 32'h0) begin
        bad++; $display("FAIL reset_data cycle %0d got %h want 00000000", i, wb_data);
      end
      total++;
      if (wb_valid !== 1'b0) begin
        bad++; $display("FAIL reset_valid cycle %0d got %b want 0", i, wb_valid);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_alu();
    mem_to_reg = 1'b0; alu_result = 32'h1234_5678; mem_data = 32'hFFFF_FFFF;
    load_type = 3'b000; byte_offset = 2'd3; wb_en = 1'b1;
    step();
    total++;
    if (wb_data !== 32'h1234_5678) begin
      bad++; $display("FAIL alu_select got %h want 12345678", wb_data);
    end
    total++;
    if (wb_valid !== 1'b1) begin
      bad++; $display("FAIL alu_valid got %b want 1", wb_valid);
    end
  endtask

  task automatic test_loads();
    logic [31:0] t_mem [7];
    logic [2:0]  t_lt  [7];
    logic [1:0]  t_off [7];
    logic [31:0] t_exp [7];
    t_mem = '{32'h80FF_7F01, 32'h80FF_7F01, 32'h8001_7FFE, 32'h8001_7FFE,
              32'h8001_7FFE, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    t_lt  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b011, 3'b111};
    t_off = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd0};
    t_exp = '{32'hFFFF_FF80, 32'h0000_00FF, 32'hFFFF_8001, 32'h0000_7FFE,
              32'h0000_7FFE, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    mem_to_reg = 1'b1; wb_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      mem_data = t_mem[i]; load_type = t_lt[i]; byte_offset = t_off[i];
      alu_result = $urandom;
      step();
      total++;
      if (wb_data !== t_exp[i] || wb_valid !== 1'b1) begin
        bad++;
        $display("FAIL load_vec%0d got %h/%b want %h/1", i, wb_data, wb_valid, t_exp[i]);
      end
    end
  endtask

  task automatic test_hold();
    mem_to_reg = 1'b0; alu_result = 32'hA5A5_A5A5; wb_en = 1'b1;
    step();
    total++;
    if (wb_data !== 32'hA5A5_A5A5) begin
      bad++; $display("FAIL hold_write got %h want a5a5a5a5", wb_data);
    end
    wb_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      alu_result = $urandom; mem_to_reg = 1'($urandom); mem_data = $urandom;
      step();
      total++;
      if (wb_data !== 32'hA5A5_A5A5 || wb_valid !== 1'b0) begin
        bad++; $display("FAIL hold_cycle%0d got %h/%b want a5a5a5a5/0", i, wb_data, wb_valid);
      end
    end
  endtask

  task automatic test_reset_during_wb();
    mem_to_reg = 1'b0; alu_result = 32'hCAFE_F00D; wb_en = 1'b1; reset = 1'b1;
    step();
    total++;
    if (wb_data !== 32'h0 || wb_valid !== 1'b0) begin
      bad++; $display("FAIL reset_over_wb got %h/%b want 00000000/0", wb_data, wb_valid);
    end
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_data;
    logic        exp_valid;
    logic        lnk;
    logic [31:0] pc;
    exp_data = 32'h0;
    for (int i = 0; i < 400; i++) begin
      mem_data = $urandom; alu_result = $urandom; mem_to_reg = 1'($urandom);
      load_type = 3'($urandom_range(0, 7)); byte_offset = 2'($urandom);
      wb_en = ($urandom_range(0, 3) != 0);
      lnk = 1'b0; pc = 32'h0;
`ifdef MEMTOREG_LINK_EN
      lnk = ($urandom_range(0, 7) == 0); pc = $urandom;
      link_sel = lnk; pc_plus_8 = pc;
`endif
      exp_valid = wb_en;
      if (wb_en) exp_data = model(mem_data, alu_result, mem_to_reg, load_type, byte_offset, lnk, pc);
      step();
      total++;
      if (wb_data !== exp_data || wb_valid !== exp_valid) begin
        bad++;
        $display("FAIL random%0d lt=%b off=%0d m2r=%b got %h/%b want %h/%b", i, load_type,
                 byte_offset, mem_to_reg, wb_data, wb_valid, exp_data, exp_valid);
      end
    end
`ifdef MEMTOREG_LINK_EN
    link_sel = 1'b0;
`endif
  endtask

`ifdef MEMTOREG_LINK_EN
  task automatic test_link();
    link_sel = 1'b1; pc_plus_8 = 32'h0000_0108; mem_to_reg = 1'b1;
    mem_data = 32'hDEAD_BEEF; load_type = 3'b011; wb_en = 1'b1;
    step();
    total++;
    if (wb_data !== 32'h0000_0108 || wb_valid !== 1'b1) begin
      bad++; $display("FAIL link_select got %h/%b want 00000108/1", wb_data, wb_valid);
    end
    link_sel = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1; mem_data = '0; alu_result = '0; mem_to_reg = 1'b0;
    load_type = 3'b0; byte_offset = 2'b0; wb_en = 1'b0;
`ifdef MEMTOREG_LINK_EN
    pc_plus_8 = '0; link_sel = 1'b0;
`endif
    #2;
    test_reset();
    test_alu();
    test_loads();
    test_hold();
    test_reset_during_wb();
    test_back_to_back();
`ifdef MEMTOREG_LINK_EN
    test_link();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
